// File: rtl/game_pkg.sv
// Shared game encodings: referee FSM states, game_state codes and widths.
// Also imported by the VGA overlay and seven-segment health display.
package game_pkg;
    localparam int HEALTH_W = 2;
    localparam int WINS_MAX = 9;

    localparam logic [1:0] GS_RUNNING = 2'd0;
    localparam logic [1:0] GS_A_WIN   = 2'd1;
    localparam logic [1:0] GS_B_WIN   = 2'd2;
    localparam logic [1:0] GS_DRAW    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_OVER    = 2'd2
    } ref_state_t;
endpackage

// File: rtl/player_life.sv
// One player's health and post-hit invulnerability window.
// health_nxt is the value the register takes at the coming edge, so the
// referee can resolve a KO on the same edge as the hit.
module player_life
    import game_pkg::*;
#(
    parameter int MAX_HEALTH   = 3,
    parameter int INVULN_TICKS = 2
) (
    input  logic                clk,
    input  logic                reset_sw,
    input  logic                load,
    input  logic                playing,
    input  logic                tick,
    input  logic                hit,
    output logic [HEALTH_W-1:0] health,
    output logic [HEALTH_W-1:0] health_nxt,
    output logic                inv
);
    logic [2:0] cnt, cnt_nxt;
    logic       hit_ok;

    // Hit qualification; a counted hit reloads the window and swallows a same-cycle tick.
    always_comb begin
        hit_ok     = playing && hit && (cnt == 3'd0) && (health != '0);
        health_nxt = health;
        cnt_nxt    = cnt;
        if (load) begin
            health_nxt = HEALTH_W'(MAX_HEALTH);
            cnt_nxt    = 3'd0;
        end else if (hit_ok) begin
            health_nxt = health - 1'b1;
            cnt_nxt    = 3'(INVULN_TICKS);
        end else if (playing && tick && (cnt != 3'd0)) begin
            cnt_nxt = cnt - 3'd1;
        end
    end

    // Health, window counter and registered invulnerable flag.
    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            health <= HEALTH_W'(MAX_HEALTH);
            cnt    <= 3'd0;
            inv    <= 1'b0;
        end else begin
            health <= health_nxt;
            cnt    <= cnt_nxt;
            inv    <= (cnt_nxt != 3'd0);
        end
    end
endmodule

// File: rtl/game_referee.sv
// Match referee: round FSM, KO/timeout resolution and win tallies.
// Optional round timer enabled by defining REFEREE_ROUND_TIMEOUT_EN;
// without it time_left stays 0 and rounds end only by KO.
module game_referee
    import game_pkg::*;
#(
    parameter int MAX_HEALTH    = 3,
    parameter int INVULN_TICKS  = 2,
    parameter int ROUND_SECONDS = 99
) (
    input  logic                clk,
    input  logic                reset_sw,
    input  logic                tick_1hz,
    input  logic                start,
    input  logic                hit_a,
    input  logic                hit_b,
    output logic [HEALTH_W-1:0] health_a,
    output logic [HEALTH_W-1:0] health_b,
    output logic                inv_a,
    output logic                inv_b,
    output logic                round_active,
    output logic [1:0]          game_state,
    output logic [3:0]          wins_a,
    output logic [3:0]          wins_b,
    output logic [6:0]          time_left
);
`ifdef REFEREE_ROUND_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    // With the timer disabled the load value is 0, so time_left never moves.
    localparam logic [6:0] TL_LOAD = TO_EN ? 7'(ROUND_SECONDS) : 7'd0;
    localparam logic [3:0] WMAX    = 4'(WINS_MAX);

    ref_state_t state, state_nxt;
    logic [1:0] gs_nxt;
    logic       inc_a, inc_b, load, playing, ko_a, ko_b, timeout;
    logic [1:0][HEALTH_W-1:0] health, health_nxt;
    logic [1:0] inv;
    logic [1:0] hit_vec;

    assign load    = start && (state != ST_PLAYING);
    assign playing = (state == ST_PLAYING);
    assign hit_vec = {hit_b, hit_a};

    for (genvar p = 0; p < 2; p++) begin : g_player
        player_life #(
            .MAX_HEALTH  (MAX_HEALTH),
            .INVULN_TICKS(INVULN_TICKS)
        ) u_life (
            .clk       (clk),
            .reset_sw  (reset_sw),
            .load      (load),
            .playing   (playing),
            .tick      (tick_1hz),
            .hit       (hit_vec[p]),
            .health    (health[p]),
            .health_nxt(health_nxt[p]),
            .inv       (inv[p])
        );
    end

    assign health_a = health[0];
    assign health_b = health[1];
    assign inv_a    = inv[0];
    assign inv_b    = inv[1];
    assign ko_a     = (health_nxt[0] == '0);
    assign ko_b     = (health_nxt[1] == '0);
    assign timeout  = TO_EN && tick_1hz && (time_left == 7'd1);

    // Next state and outcome; KO outranks timeout, timeout compares next health.
    always_comb begin
        state_nxt = state;
        gs_nxt    = game_state;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_nxt = ST_PLAYING;
                    gs_nxt    = GS_RUNNING;
                end
            end
            ST_PLAYING: begin
                if (ko_a || ko_b) begin
                    state_nxt = ST_OVER;
                    gs_nxt    = (ko_a && ko_b) ? GS_DRAW : (ko_a ? GS_B_WIN : GS_A_WIN);
                end else if (timeout) begin
                    state_nxt = ST_OVER;
                    if (health_nxt[0] > health_nxt[1])      gs_nxt = GS_A_WIN;
                    else if (health_nxt[1] > health_nxt[0]) gs_nxt = GS_B_WIN;
                    else                                    gs_nxt = GS_DRAW;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        inc_a = playing && (state_nxt == ST_OVER) && (gs_nxt == GS_A_WIN);
        inc_b = playing && (state_nxt == ST_OVER) && (gs_nxt == GS_B_WIN);
    end

    // State, outcome, round flag, tallies and round timer.
    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            state        <= ST_IDLE;
            game_state   <= GS_RUNNING;
            round_active <= 1'b0;
            wins_a       <= 4'd0;
            wins_b       <= 4'd0;
            time_left    <= 7'd0;
        end else begin
            state        <= state_nxt;
            game_state   <= gs_nxt;
            round_active <= (state_nxt == ST_PLAYING);
            if (inc_a && wins_a != WMAX) wins_a <= wins_a + 4'd1;
            if (inc_b && wins_b != WMAX) wins_b <= wins_b + 4'd1;
            if (load)
                time_left <= TL_LOAD;
            else if (playing && tick_1hz && time_left != 7'd0)
                time_left <= time_left - 7'd1;
        end
    end
endmodule
